// File: rtl/zapper_hit_sequencer.sv
// Light-gun hit sequencer: blanks the screen for one frame, then flashes each
// enabled duck's box for one frame each, and reports which box the photodiode saw.
module zapper_hit_sequencer #(
  parameter int NUM_TARGETS = 2,
  parameter int BOX_W       = 32,
  parameter int BOX_H       = 32,
  parameter int LIGHT_MIN   = 64,
  parameter int COOLDOWN    = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_tick,
  input  logic                      valid,
  input  logic [9:0]                col,
  input  logic [9:0]                row,
  input  logic                      trigger,
  input  logic                      light,
  input  logic [NUM_TARGETS-1:0]    target_en,
  input  logic [10*NUM_TARGETS-1:0] target_x,
  input  logic [10*NUM_TARGETS-1:0] target_y,
  output logic [1:0]                scene,
  output logic                      box_on,
  output logic                      busy,
  output logic                      hit_valid,
  output logic                      hit,
  output logic [1:0]                hit_id
);

  // state    | meaning
  // IDLE     | normal scene, waiting for a synchronized trigger rise
  // ARM      | trigger accepted, waiting for the next frame start
  // BLACK    | one blanked frame; light here means the gun sees a lamp
  // TARGET   | one frame per enabled duck showing its white box
  // DONE     | one-clk result strobe
  // COOLDOWN | counting frames before a new trigger is accepted

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_BLACK, S_TARGET, S_DONE, S_COOLDOWN
  } state_t;

  localparam logic [1:0] SCENE_NORMAL = 2'd0;
  localparam logic [1:0] SCENE_BLACK  = 2'd1;
  localparam logic [1:0] SCENE_TARGET = 2'd2;
  localparam int CD_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

  state_t          state;
  logic [1:0]      idx;
  logic [CD_W-1:0] cd_cnt;
  logic [9:0]      light_cnt;
  logic            trig_meta, trig_sync, trig_prev;
  logic            light_meta, light_sync;
  logic            trig_rise, light_seen;
  logic [2:0]      first_en, next_en;
  logic [9:0]      box_x, box_y;
  logic            in_x, in_y;

  // Returns {found, index} of the lowest enabled duck at or above start_idx.
  function automatic logic [2:0] find_en(input logic [NUM_TARGETS-1:0] en,
                                         input logic [2:0] start_idx);
    logic [2:0] res;
    res = '0;
    for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
      if (en[i] && (i >= int'(start_idx))) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_meta  <= 1'b0;
      trig_sync  <= 1'b0;
      trig_prev  <= 1'b0;
      light_meta <= 1'b0;
      light_sync <= 1'b0;
    end else begin
      trig_meta  <= trigger;
      trig_sync  <= trig_meta;
      trig_prev  <= trig_sync;
      light_meta <= light;
      light_sync <= light_meta;
    end
  end

  assign trig_rise = trig_sync & ~trig_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      light_cnt <= '0;
    end else if (frame_tick) begin
      light_cnt <= '0;
    end else if (valid && light_sync && (light_cnt != '1)) begin
      light_cnt <= light_cnt + 10'd1;
    end
  end

  assign light_seen = (light_cnt >= 10'(LIGHT_MIN));
  assign first_en   = find_en(target_en, 3'd0);
  assign next_en    = find_en(target_en, {1'b0, idx} + 3'd1);

  always_comb begin
    box_x = '0;
    box_y = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (idx == 2'(i)) begin
        box_x = target_x[10*i +: 10];
        box_y = target_y[10*i +: 10];
      end
    end
  end

  // 11-bit compare keeps a box near the right/bottom edge from wrapping to 0.
  assign in_x = ({1'b0, col} >= {1'b0, box_x}) &&
                ({1'b0, col} <  ({1'b0, box_x} + 11'(BOX_W)));
  assign in_y = ({1'b0, row} >= {1'b0, box_y}) &&
                ({1'b0, row} <  ({1'b0, box_y} + 11'(BOX_H)));

  assign box_on = (state == S_TARGET) && valid && in_x && in_y;
  assign busy   = (state != S_IDLE) && (state != S_COOLDOWN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      scene     <= SCENE_NORMAL;
      idx       <= '0;
      cd_cnt    <= '0;
      hit_valid <= 1'b0;
      hit       <= 1'b0;
      hit_id    <= '0;
    end else begin
      hit_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trig_rise) state <= S_ARM;
        end
        S_ARM: begin
          if (frame_tick) begin
            state <= S_BLACK;
            scene <= SCENE_BLACK;
          end
        end
        S_BLACK: begin
          if (frame_tick) begin
            if (light_seen || !first_en[2]) begin
              state     <= S_DONE;
              scene     <= SCENE_NORMAL;
              hit_valid <= 1'b1;
              hit       <= 1'b0;
              hit_id    <= '0;
            end else begin
              state <= S_TARGET;
              scene <= SCENE_TARGET;
              idx   <= first_en[1:0];
            end
          end
        end
        S_TARGET: begin
          if (frame_tick) begin
            if (light_seen) begin
              state     <= S_DONE;
              scene     <= SCENE_NORMAL;
              hit_valid <= 1'b1;
              hit       <= 1'b1;
              hit_id    <= idx;
            end else if (next_en[2]) begin
              idx <= next_en[1:0];
            end else begin
              state     <= S_DONE;
              scene     <= SCENE_NORMAL;
              hit_valid <= 1'b1;
              hit       <= 1'b0;
              hit_id    <= '0;
            end
          end
        end
        S_DONE: begin
          state  <= S_COOLDOWN;
          cd_cnt <= CD_W'(COOLDOWN);
        end
        S_COOLDOWN: begin
          if (frame_tick) begin
            if (cd_cnt <= CD_W'(1)) state <= S_IDLE;
            else                    cd_cnt <= cd_cnt - CD_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          scene <= SCENE_NORMAL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zapper_hit_sequencer.sv
// Scoreboard bench for the light-gun hit sequencer using short synthetic frames
// that scan a small window around the duck boxes.
module tb_zapper_hit_sequencer;

  localparam int NT = 2;
  localparam int BW = 32;
  localparam int BH = 32;
  localparam int CD = 15;
  localparam int SCAN_C0 = 90;
  localparam int SCAN_NC = 50;
  localparam int SCAN_R0 = 200;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            frame_tick = 1'b0;
  logic            valid = 1'b0;
  logic [9:0]      col = '0;
  logic [9:0]      row = '0;
  logic            trigger = 1'b0;
  logic            light = 1'b0;
  logic [NT-1:0]   target_en = 2'b11;
  logic [10*NT-1:0] target_x = {10'd100, 10'd40};
  logic [10*NT-1:0] target_y = {10'd200, 10'd200};
  logic [1:0]      scene;
  logic            box_on;
  logic            busy;
  logic            hit_valid;
  logic            hit;
  logic [1:0]      hit_id;

  typedef struct {
    logic       hit;
    logic [1:0] id;
    int         ticks;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int n_checks = 0;
  int n_fail = 0;
  int tick_cnt = 0;
  int trig_tick = 0;
  int box_cnt = 0;
  int lx = 0;
  int ly = 0;

  int   pc [12] = '{619, 620, 639, 0, 11, 630, 630, 630, 630, 1010, 999, 8};
  int   pr [12] = '{110, 110, 110, 110, 110, 99, 100, 131, 132, 110, 110, 110};
  int   px [12] = '{620, 620, 620, 620, 620, 620, 620, 620, 620, 1000, 1000, 1000};
  logic pe [12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  zapper_hit_sequencer #(
    .NUM_TARGETS(NT), .BOX_W(BW), .BOX_H(BH), .LIGHT_MIN(64), .COOLDOWN(CD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .valid(valid),
    .col(col), .row(row), .trigger(trigger), .light(light),
    .target_en(target_en), .target_x(target_x), .target_y(target_y),
    .scene(scene), .box_on(box_on), .busy(busy), .hit_valid(hit_valid),
    .hit(hit), .hit_id(hit_id)
  );

  always #5 clk = ~clk;

  // Pops the expected result for every strobe the DUT produces.
  always @(negedge clk) begin
    if (rst_n && hit_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_result: hit=%0d hit_id=%0d, required no strobe", hit, hit_id);
      end else begin
        mon_e = exp_q.pop_front();
        if (hit !== mon_e.hit || hit_id !== mon_e.id || (tick_cnt - trig_tick) != mon_e.ticks) begin
          n_fail++;
          $display("FAIL result: hit=%0d hit_id=%0d ticks=%0d, required hit=%0d hit_id=%0d ticks=%0d",
                   hit, hit_id, tick_cnt - trig_tick, mon_e.hit, mon_e.id, mon_e.ticks);
        end
      end
    end
  end

  function automatic logic in_light_box(input int c, input int r);
    return (c >= lx) && (c < lx + BW) && (r >= ly) && (r < ly + BH);
  endfunction

  task automatic push_exp(input logic h, input logic [1:0] id, input int ticks);
    exp_t e;
    e.hit = h;
    e.id = id;
    e.ticks = ticks;
    exp_q.push_back(e);
  endtask

  // mode 0: dark, 1: lit inside the aim box, 2: first lit_n scanned pixels lit
  task automatic run_frame(input int nr, input int mode, input int lit_n);
    int k;
    @(negedge clk);
    frame_tick = 1'b1;
    valid = 1'b0;
    light = 1'b0;
    tick_cnt++;
    @(negedge clk);
    frame_tick = 1'b0;
    k = 0;
    box_cnt = 0;
    for (int r = 0; r < nr; r++) begin
      for (int c = 0; c < SCAN_NC; c++) begin
        col = 10'(SCAN_C0 + c);
        row = 10'(SCAN_R0 + r);
        valid = 1'b1;
        case (mode)
          1:       light = in_light_box(SCAN_C0 + c, SCAN_R0 + r);
          2:       light = (k < lit_n);
          default: light = 1'b0;
        endcase
        k++;
        #1;
        if (box_on === 1'b1) box_cnt++;
        @(negedge clk);
      end
    end
    valid = 1'b0;
    light = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic cool_down();
    repeat (CD) run_frame(0, 0, 0);
  endtask

  task automatic pull_trigger();
    @(negedge clk);
    trigger = 1'b1;
    repeat (4) @(negedge clk);
    trigger = 1'b0;
    trig_tick = tick_cnt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b1;
    col = 10'd110;
    row = 10'd201;
    repeat (3) @(negedge clk);
    n_checks++;
    if (scene !== 2'd0 || box_on !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_scene: scene=%0d box_on=%0d busy=%0d, required 0 0 0", scene, box_on, busy);
    end
    n_checks++;
    if (hit_valid !== 1'b0 || hit !== 1'b0 || hit_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_result: hit_valid=%0d hit=%0d hit_id=%0d, required 0 0 0", hit_valid, hit, hit_id);
    end
    valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_miss_sequence();
    push_exp(1'b0, 2'd0, 4);
    pull_trigger();
    n_checks++;
    if (busy !== 1'b1 || scene !== 2'd0) begin
      n_fail++;
      $display("FAIL arm_state: busy=%0d scene=%0d, required 1 0", busy, scene);
    end
    run_frame(4, 0, 0);
    n_checks++;
    if (scene !== 2'd1 || box_cnt != 0) begin
      n_fail++;
      $display("FAIL black_frame: scene=%0d box_pixels=%0d, required 1 0", scene, box_cnt);
    end
    run_frame(4, 0, 0);
    n_checks++;
    if (scene !== 2'd2 || box_cnt != 0) begin
      n_fail++;
      $display("FAIL target0_frame: scene=%0d box_pixels=%0d, required 2 0", scene, box_cnt);
    end
    run_frame(4, 0, 0);
    n_checks++;
    if (scene !== 2'd2 || box_cnt != 128) begin
      n_fail++;
      $display("FAIL target1_frame: scene=%0d box_pixels=%0d, required 2 128", scene, box_cnt);
    end
    run_frame(4, 0, 0);
    n_checks++;
    if (scene !== 2'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done: scene=%0d busy=%0d, required 0 0", scene, busy);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL miss_result_seen: pending=%0d, required 0", exp_q.size());
    end
    cool_down();
  endtask

  task automatic test_hit();
    push_exp(1'b1, 2'd1, 4);
    pull_trigger();
    run_frame(4, 0, 0);
    run_frame(4, 0, 0);
    lx = 100;
    ly = 200;
    run_frame(4, 1, 0);
    run_frame(4, 0, 0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL hit_result_seen: pending=%0d, required 0", exp_q.size());
    end
    cool_down();
  endtask

  task automatic test_lamp();
    push_exp(1'b0, 2'd0, 2);
    pull_trigger();
    run_frame(4, 2, 1000);
    n_checks++;
    if (scene !== 2'd1) begin
      n_fail++;
      $display("FAIL lamp_black: scene=%0d, required 1", scene);
    end
    run_frame(4, 2, 1000);
    n_checks++;
    if (scene !== 2'd0 || box_cnt != 0) begin
      n_fail++;
      $display("FAIL lamp_no_target: scene=%0d box_pixels=%0d, required 0 0", scene, box_cnt);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL lamp_result_seen: pending=%0d, required 0", exp_q.size());
    end
    cool_down();
  endtask

  task automatic test_enables();
    target_en = 2'b00;
    push_exp(1'b0, 2'd0, 2);
    pull_trigger();
    run_frame(4, 0, 0);
    run_frame(4, 0, 0);
    n_checks++;
    if (scene !== 2'd0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL no_ducks: scene=%0d pending=%0d, required 0 0", scene, exp_q.size());
    end
    cool_down();
    target_en = 2'b10;
    push_exp(1'b0, 2'd0, 3);
    pull_trigger();
    run_frame(4, 0, 0);
    run_frame(4, 0, 0);
    n_checks++;
    if (scene !== 2'd2 || box_cnt != 128) begin
      n_fail++;
      $display("FAIL only_duck1: scene=%0d box_pixels=%0d, required 2 128", scene, box_cnt);
    end
    run_frame(4, 0, 0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL only_duck1_result: pending=%0d, required 0", exp_q.size());
    end
    cool_down();
    target_en = 2'b11;
  endtask

  task automatic test_threshold();
    push_exp(1'b0, 2'd0, 2);
    pull_trigger();
    run_frame(4, 2, 64);
    run_frame(4, 0, 0);
    n_checks++;
    if (scene !== 2'd0 || box_cnt != 0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL lamp_at_min: scene=%0d box_pixels=%0d pending=%0d, required 0 0 0",
               scene, box_cnt, exp_q.size());
    end
    cool_down();
    push_exp(1'b1, 2'd0, 3);
    pull_trigger();
    run_frame(4, 2, 63);
    run_frame(4, 2, 64);
    n_checks++;
    if (scene !== 2'd2) begin
      n_fail++;
      $display("FAIL below_min_continues: scene=%0d, required 2", scene);
    end
    run_frame(4, 0, 0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL hit_at_min_result: pending=%0d, required 0", exp_q.size());
    end
    cool_down();
  endtask

  task automatic test_box_edge();
    target_en = 2'b01;
    target_x[9:0] = 10'd620;
    target_y[9:0] = 10'd100;
    push_exp(1'b0, 2'd0, 3);
    pull_trigger();
    valid = 1'b1;
    col = 10'd630;
    row = 10'd110;
    #1;
    n_checks++;
    if (box_on !== 1'b0) begin
      n_fail++;
      $display("FAIL box_off_in_arm: box_on=%0d, required 0", box_on);
    end
    valid = 1'b0;
    run_frame(4, 0, 0);
    run_frame(4, 0, 0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      target_x[9:0] = 10'(px[i]);
      col = 10'(pc[i]);
      row = 10'(pr[i]);
      valid = 1'b1;
      #1;
      n_checks++;
      if (box_on !== pe[i]) begin
        n_fail++;
        $display("FAIL box_edge[%0d] x=%0d col=%0d row=%0d: box_on=%0d, required %0d",
                 i, px[i], pc[i], pr[i], box_on, pe[i]);
      end
    end
    @(negedge clk);
    valid = 1'b0;
    col = 10'd630;
    row = 10'd110;
    #1;
    n_checks++;
    if (box_on !== 1'b0) begin
      n_fail++;
      $display("FAIL box_needs_valid: box_on=%0d, required 0", box_on);
    end
    target_x[9:0] = 10'd40;
    target_y[9:0] = 10'd200;
    run_frame(4, 0, 0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL box_edge_result: pending=%0d, required 0", exp_q.size());
    end
    cool_down();
    target_en = 2'b11;
  endtask

  task automatic test_tick_collision();
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    trigger = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || scene !== 2'd0) begin
      n_fail++;
      $display("FAIL collision_arm: busy=%0d scene=%0d, required 1 0", busy, scene);
    end
    trig_tick = tick_cnt;
    push_exp(1'b0, 2'd0, 4);
    run_frame(4, 0, 0);
    n_checks++;
    if (scene !== 2'd1) begin
      n_fail++;
      $display("FAIL collision_black: scene=%0d, required 1", scene);
    end
    repeat (3) run_frame(4, 0, 0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL collision_result: pending=%0d, required 0", exp_q.size());
    end
    cool_down();
  endtask

  task automatic test_cooldown();
    push_exp(1'b0, 2'd0, 4);
    pull_trigger();
    repeat (4) run_frame(4, 0, 0);
    @(negedge clk);
    trigger = 1'b1;
    repeat (14) run_frame(0, 0, 0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_trigger_cooldown: busy=%0d, required 0", busy);
    end
    repeat (4) run_frame(0, 0, 0);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL held_trigger_retrigger: busy=%0d, required 0", busy);
    end
    trigger = 1'b0;
    repeat (4) @(negedge clk);

    target_en = 2'b01;
    push_exp(1'b0, 2'd0, 3);
    pull_trigger();
    repeat (3) run_frame(4, 0, 0);
    repeat (14) run_frame(0, 0, 0);
    @(negedge clk);
    trigger = 1'b1;
    repeat (4) @(negedge clk);
    trigger = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL cooldown_trigger_ignored: busy=%0d, required 0", busy);
    end
    run_frame(0, 0, 0);
    push_exp(1'b0, 2'd0, 3);
    pull_trigger();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL trigger_after_cooldown: busy=%0d, required 1", busy);
    end
    repeat (3) run_frame(4, 0, 0);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL cooldown_results: pending=%0d, required 0", exp_q.size());
    end
    cool_down();
    target_en = 2'b11;
  endtask

  task automatic test_reset_abort();
    pull_trigger();
    run_frame(4, 0, 0);
    run_frame(4, 0, 0);
    @(negedge clk);
    valid = 1'b1;
    col = 10'd50;
    row = 10'd210;
    #1;
    n_checks++;
    if (box_on !== 1'b1 || scene !== 2'd2) begin
      n_fail++;
      $display("FAIL pre_reset_target: box_on=%0d scene=%0d, required 1 2", box_on, scene);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (scene !== 2'd0 || busy !== 1'b0 || box_on !== 1'b0 || hit_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_abort: scene=%0d busy=%0d box_on=%0d hit_valid=%0d, required 0 0 0 0",
               scene, busy, box_on, hit_valid);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b0;
    repeat (5) run_frame(4, 0, 0);
    n_checks++;
    if (busy !== 1'b0 || scene !== 2'd0) begin
      n_fail++;
      $display("FAIL after_abort_idle: busy=%0d scene=%0d, required 0 0", busy, scene);
    end
  endtask

  initial begin
    test_reset();
    test_miss_sequence();
    test_hit();
    test_lamp();
    test_enables();
    test_threshold();
    test_box_edge();
    test_tick_collision();
    test_cooldown();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zapper_hit_sequencer.md
Name: zapper_hit_sequencer

Overview:
- Controls the light-gun hit-detection sequence for the display path.
- On a trigger pull, it takes over the scene for several frames. It blanks the screen for one frame, then shows one white target box per frame for each enabled duck, and samples the photodiode in each of those frames.
- It reports either a hit with the duck index, or a miss. It sits between the VGA timing generator, the game logic that supplies the duck positions, and the pixel colour mux.

Parameters:
- NUM_TARGETS, 2, number of ducks (1..4)
- BOX_W, 32, target box width in pixels
- BOX_H, 32, target box height in pixels
- LIGHT_MIN, 64, minimum number of lit active-pixel clocks in one frame that counts as "light seen"
- COOLDOWN, 15, frames after DONE before a new trigger is accepted

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-clk pulse at the start of each frame
- valid  in  1  visible-area flag from VGA timing
- col  in  10  current pixel column
- row  in  10  current pixel row
- trigger  in  1  gun trigger, asynchronous
- light  in  1  photodiode, asynchronous, 1 = bright
- target_en  in  NUM_TARGETS  per-duck enable
- target_x  in  10*NUM_TARGETS  box left edge, duck i at bits [10i+9:10i]
- target_y  in  10*NUM_TARGETS  box top edge
- scene  out  2  0=NORMAL, 1=BLACK, 2=TARGET
- box_on  out  1  current pixel is inside the active target box
- busy  out  1  a sequence is in progress (not IDLE and not COOLDOWN)
- hit_valid  out  1  one-clk result strobe
- hit  out  1  1 = duck hit, 0 = miss (qualified by hit_valid)
- hit_id  out  2  index of the duck hit (qualified by hit_valid and hit)

Behaviour:
- Reset: all outputs are 0, the state is IDLE, the counters are 0, and the synchronizers are cleared.
- trigger and light each pass through a 2-flop synchronizer. A trigger rising edge is detected on the synchronized signal.
- States: IDLE, ARM, BLACK, TARGET, DONE, COOLDOWN.
- IDLE:
  - scene=NORMAL.
  - A synchronized trigger rise moves to ARM. The trigger is ignored in every other state; no queuing.
- ARM: waits for frame_tick, then moves to BLACK. scene stays NORMAL until then.
- BLACK: one full frame with scene=BLACK and light_cnt counting. At the next frame_tick:
  - If light_cnt >= LIGHT_MIN, the gun is aimed at a lamp. Go to DONE with a miss.
  - Otherwise idx is set to the lowest enabled duck and the state moves to TARGET.
  - If no duck is enabled, go to DONE with a miss.
- TARGET:
  - One frame per enabled duck idx, with scene=TARGET.
  - box_on = valid && col in [x_idx, x_idx+BOX_W-1] && row in [y_idx, y_idx+BOX_H-1].
  - Compare at 11-bit width so x+BOX_W does not wrap; a box clipped at the edge is simply truncated.
  - At frame_tick:
    - If light_cnt >= LIGHT_MIN, go to DONE with hit=1 and hit_id=idx.
    - Else advance to the next enabled duck.
    - If there is none left, go to DONE with a miss.
  - target_en and the positions are sampled live each cycle. A duck disabled mid-frame still completes its frame.
- light_cnt:
  - 10-bit, saturating.
  - Cleared at every frame_tick.
  - Increments when valid && light_sync.
- DONE:
  - One clk, with hit_valid=1 and the registered hit and hit_id. scene=NORMAL.
  - hit_id is 0 on a miss.
  - Then moves to COOLDOWN.
- COOLDOWN:
  - Counts COOLDOWN frame_ticks, then moves to IDLE.
  - A trigger held high through COOLDOWN does not restart the sequence; a new rising edge is required.
- frame_tick in the same cycle as a trigger rise in IDLE:
  - The state goes to ARM.
  - BLACK starts only on the following frame_tick.
- box_on is combinational from col/row and the registered state; it is 0 outside TARGET.
- scene and hit are registered.
- Reset asserted mid-sequence aborts immediately to IDLE with outputs at 0; no hit_valid is issued.

Test Plan:
1. Trigger rise in IDLE, light=0 throughout, both ducks enabled -> scene goes BLACK, TARGET(0), TARGET(1) on consecutive frames. Then hit_valid=1, hit=0, hit_id=0, busy=0 after 15 further frames.
2. light driven high only for pixels inside duck 1's box, with duck 1 at (100,200) -> hit_valid with hit=1, hit_id=1, after exactly 3 frames following ARM.
3. light held high for the whole sequence -> abort after the BLACK frame. hit=0, TARGET is never entered.
4. target_en=2'b00 -> BLACK, then DONE with a miss. target_en=2'b10 -> the only TARGET frame shows duck 1.
5. Box at x=620 -> box_on is asserted for cols 620..639 only, with no wrap to col 0..11.
6. Trigger rise during COOLDOWN is ignored; a held trigger does not retrigger; rst_n low mid-TARGET -> scene=0 immediately and no hit_valid.
